bkm68x_host_master: RTL

Bus initiator for the BKM-68X slot interface: plays the monitor side of the multiplexed 8-bit slot bus that `monitor_interface` answers as a card. It converts single-register read/write requests from local logic into address-phase/data-phase strobe sequences on `clk_rw`, captures read data, drives the card reset line and synchronizes the card interrupt. It is used in bench and loop-back builds to exercise the card-side logic without a real monitor.

---
 rtl/bkm68x_pkg.sv | 49 ++++
 rtl/bkm68x_sync2.sv | 33 +++
 rtl/bkm68x_host_master.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/bkm68x_pkg.sv
// Shared definitions for the BKM-68X slot bus.
// Contents:
//   state_t         - host master sequencer states
//   bus_t           - bundle of all slot bus lines driven by the host
//   BUS_IDLE        - bus values while idle (card out of reset)
//   BUS_RESET       - bus values while the card is held in reset
//   DEF_*           - default strobe timing, also used by card-side benches
//   countLoad       - down-counter load value for a phase lasting N cycles
package bkm68x_pkg;

  typedef enum logic [3:0] {
    ST_RST_HOLD,
    ST_IDLE,
    ST_A_SETUP,
    ST_A_HI,
    ST_A_LO,
    ST_D_SETUP,
    ST_D_HI,
    ST_D_LO,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic       slotX;
    logic       clkRw;
    logic       axD;
    logic       rWx;
    logic       resetX;
    logic [7:0] adOut;
    logic       adOeX;
  } bus_t;

  localparam bus_t BUS_IDLE = '{slotX: 1'b1, clkRw: 1'b0, axD: 1'b0, rWx: 1'b1,
                                resetX: 1'b1, adOut: 8'h00, adOeX: 1'b1};

  localparam bus_t BUS_RESET = '{slotX: 1'b1, clkRw: 1'b0, axD: 1'b0, rWx: 1'b1,
                                 resetX: 1'b0, adOut: 8'h00, adOeX: 1'b1};

  localparam int unsigned DEF_T_SETUP    = 2;
  localparam int unsigned DEF_T_HI       = 4;
  localparam int unsigned DEF_T_LO       = 4;
  localparam int unsigned DEF_RESET_HOLD = 16;

  // A phase of N cycles loads N-1 so that it advances when the count hits 0.
  function automatic logic [7:0] countLoad(input int unsigned cycles);
    return 8'(cycles - 1);
  endfunction

endpackage

// File: rtl/bkm68x_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   i_clk    - destination clock
//   i_reset  - asynchronous active-high reset, flops go to RESET_VAL
//   i_async  - asynchronous input
//   o_sync   - synchronized copy of i_async (two clock delay)
module bkm68x_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Both stages reset to the inactive level so a reset never produces a
  // spurious active pulse downstream.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/bkm68x_host_master.sv
// Host-side (monitor) initiator for the BKM-68X multiplexed slot bus.
// Turns single register read/write requests into an address phase and a
// data phase, each made of setup / strobe-high / strobe-low intervals on
// clk_rw, captures read data, pulses the card reset and synchronizes the
// card interrupt.
// Ports:
//   clk_20mhz, reset      - system clock, asynchronous active-high reset
//   req, we, addr, wdata  - transaction request, sampled only when idle
//   card_reset            - card reset pulse request, sampled only when idle
//   busy, done, rdata     - status, end-of-transaction pulse, last read data
//   irq                   - synchronized active-high copy of int_x
//   slot_x_int_x, clk_rw, ax_d, r_wx, reset_x, ad_out, ad_oe_x - bus drive
//   ad_in, int_x          - bus sample value, card interrupt (active low)
// Timing parameters are in clk_20mhz cycles, valid range 1..255.
module bkm68x_host_master
  import bkm68x_pkg::*;
#(
  parameter int unsigned T_SETUP    = DEF_T_SETUP,
  parameter int unsigned T_HI       = DEF_T_HI,
  parameter int unsigned T_LO       = DEF_T_LO,
  parameter int unsigned RESET_HOLD = DEF_RESET_HOLD
) (
  input  logic       clk_20mhz,
  input  logic       reset,
  input  logic       req,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic       card_reset,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       irq,
  output logic       slot_x_int_x,
  output logic       clk_rw,
  output logic       ax_d,
  output logic       r_wx,
  output logic       reset_x,
  output logic [7:0] ad_out,
  output logic       ad_oe_x,
  input  logic [7:0] ad_in,
  input  logic       int_x
);

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_count;
  logic [7:0] w_countNext;
  logic       w_accept;

  logic       r_we;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic       w_we;
  logic [7:0] w_addr;
  logic [7:0] w_wdata;

  bus_t       r_bus;
  bus_t       w_busNext;
  logic       r_busy;
  logic       w_busyNext;
  logic       r_done;
  logic       w_doneNext;
  logic [7:0] r_rdata;
  logic       w_intSync;

  // Duration of each timed state expressed as a down-counter load value.
  function automatic logic [7:0] entryCount(input state_t s);
    case (s)
      ST_RST_HOLD:            entryCount = countLoad(RESET_HOLD);
      ST_A_SETUP, ST_D_SETUP: entryCount = countLoad(T_SETUP);
      ST_A_HI, ST_D_HI:       entryCount = countLoad(T_HI);
      ST_A_LO, ST_D_LO:       entryCount = countLoad(T_LO);
      default:                entryCount = 8'd0;
    endcase
  endfunction

  // Next-state logic. card_reset has priority over req in IDLE; every timed
  // state advances once its counter has run down to zero.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_RST_HOLD: if (r_count == 8'd0) w_nextState = ST_IDLE;
      ST_IDLE: begin
        if (card_reset) begin
          w_nextState = ST_RST_HOLD;
        end else if (req) begin
          w_nextState = ST_A_SETUP;
          w_accept    = 1'b1;
        end
      end
      ST_A_SETUP: if (r_count == 8'd0) w_nextState = ST_A_HI;
      ST_A_HI:    if (r_count == 8'd0) w_nextState = ST_A_LO;
      ST_A_LO:    if (r_count == 8'd0) w_nextState = ST_D_SETUP;
      ST_D_SETUP: if (r_count == 8'd0) w_nextState = ST_D_HI;
      ST_D_HI:    if (r_count == 8'd0) w_nextState = ST_D_LO;
      ST_D_LO:    if (r_count == 8'd0) w_nextState = ST_DONE;
      ST_DONE:    w_nextState = ST_IDLE;
      default:    w_nextState = ST_RST_HOLD;
    endcase

    if (w_nextState != r_state) begin
      w_countNext = entryCount(w_nextState);
    end else if (r_count != 8'd0) begin
      w_countNext = r_count - 8'd1;
    end else begin
      w_countNext = r_count;
    end
  end

  // On the accept edge the request fields are still only on the inputs, so
  // the output decode uses them directly; afterwards the latched copy.
  assign w_we    = w_accept ? we    : r_we;
  assign w_addr  = w_accept ? addr  : r_addr;
  assign w_wdata = w_accept ? wdata : r_wdata;

  // Output decode from the state being entered, so every registered output
  // lines up exactly with the cycles spent in that state.
  always_comb begin
    w_busNext  = BUS_IDLE;
    w_busyNext = 1'b1;
    w_doneNext = 1'b0;
    case (w_nextState)
      ST_RST_HOLD: w_busNext = BUS_RESET;
      ST_IDLE:     w_busyNext = 1'b0;
      ST_A_SETUP, ST_A_HI, ST_A_LO: begin
        w_busNext.slotX = 1'b0;
        w_busNext.axD   = 1'b1;
        w_busNext.rWx   = ~w_we;
        w_busNext.adOut = w_addr;
        w_busNext.adOeX = 1'b0;
        w_busNext.clkRw = (w_nextState == ST_A_HI);
      end
      ST_D_SETUP, ST_D_HI, ST_D_LO: begin
        w_busNext.slotX = 1'b0;
        w_busNext.axD   = 1'b0;
        w_busNext.rWx   = ~w_we;
        w_busNext.adOut = w_we ? w_wdata : 8'h00;
        w_busNext.adOeX = ~w_we;
        w_busNext.clkRw = (w_nextState == ST_D_HI);
      end
      ST_DONE:     w_doneNext = 1'b1;
      default:     w_busNext = BUS_IDLE;
    endcase
  end

  // State register and phase counter; reset always restarts the card reset hold.
  always_ff @(posedge clk_20mhz or posedge reset) begin
    if (reset) begin
      r_state <= ST_RST_HOLD;
      r_count <= countLoad(RESET_HOLD);
    end else begin
      r_state <= w_nextState;
      r_count <= w_countNext;
    end
  end

  // Request latch plus registered bus and status outputs.
  always_ff @(posedge clk_20mhz or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= 8'h00;
      r_wdata <= 8'h00;
      r_bus   <= BUS_RESET;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= we;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      r_bus  <= w_busNext;
      r_busy <= w_busyNext;
      r_done <= w_doneNext;
    end
  end

  // Read data is sampled on the edge that closes the data strobe-high window.
  always_ff @(posedge clk_20mhz or posedge reset) begin
    if (reset) begin
      r_rdata <= 8'h00;
    end else if (r_state == ST_D_HI && r_count == 8'd0 && !r_we) begin
      r_rdata <= ad_in;
    end
  end

  bkm68x_sync2 #(.RESET_VAL(1'b1)) u_intSync (
    .i_clk   (clk_20mhz),
    .i_reset (reset),
    .i_async (int_x),
    .o_sync  (w_intSync)
  );

  assign busy         = r_busy;
  assign done         = r_done;
  assign rdata        = r_rdata;
  assign irq          = ~w_intSync;
  assign slot_x_int_x = r_bus.slotX;
  assign clk_rw       = r_bus.clkRw;
  assign ax_d         = r_bus.axD;
  assign r_wx         = r_bus.rWx;
  assign reset_x      = r_bus.resetX;
  assign ad_out       = r_bus.adOut;
  assign ad_oe_x      = r_bus.adOeX;

endmodule
